queue_push_arbiter: RTL and testbench

- Shares one FIFO buffer among NUM_REQS producers.
- Each cycle, a round-robin arbiter picks at most one valid requester and pushes its payload into an internal circular queue. The queue holds SIZE entries and tags each entry with the requester index.
- A single consumer drains the queue through a valid/ready port.
- It sits between several issue/response sources and a shared downstream stage that accepts one item per cycle.

---
 rtl/queue_push_arbiter_if.sv | 41 ++++
 rtl/queue_push_arbiter.sv | 113 +++++++++++
 tb/tb_queue_push_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/queue_push_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : queue_push_arbiter_if
// Description : Handshake bundle between NUM_REQS producers, the shared push
//               queue and its single consumer.
//               Producer side : req_valid, req_data (in), req_ready (out)
//               Consumer side : out_valid, out_data, out_tag (out), out_ready (in)
//               Status        : count, full, empty (out)
//               slave modport  = queue side, master modport = environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface queue_push_arbiter_if #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 8,
  parameter int SIZE     = 4
);
  localparam int TAGW = $clog2(NUM_REQS);
  localparam int CNTW = $clog2(SIZE) + 1;

  logic [NUM_REQS-1:0]       req_valid;
  logic [NUM_REQS*DATAW-1:0] req_data;
  logic [NUM_REQS-1:0]       req_ready;
  logic                      out_valid;
  logic [DATAW-1:0]          out_data;
  logic [TAGW-1:0]           out_tag;
  logic                      out_ready;
  logic [CNTW-1:0]           count;
  logic                      full;
  logic                      empty;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_tag, count, full, empty
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_tag, count, full, empty
  );
endinterface
`default_nettype wire

// File: rtl/queue_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : queue_push_arbiter
// Description : Round-robin arbiter that pushes at most one requester payload
//               per cycle into a shared circular queue; each entry carries
//               the index of the requester that produced it. One consumer
//               drains the queue through a valid/ready port.
//               clk   : rising-edge clock
//               reset : asynchronous, active-low reset
//               bus   : queue_push_arbiter_if.slave (request, output, status)
// Revision    : 1.0 - initial release
// ============================================================================
module queue_push_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 8,
  parameter int SIZE     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  queue_push_arbiter_if.slave   bus
);
  localparam int TAGW = $clog2(NUM_REQS);
  localparam int CNTW = $clog2(SIZE) + 1;
  localparam int PTRW = $clog2(SIZE);
  localparam int ENTW = DATAW + TAGW;

  logic [TAGW-1:0] r_rr_ptr;
  logic [PTRW-1:0] r_wr_ptr;
  logic [PTRW-1:0] r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic [ENTW-1:0] r_mem [SIZE];

  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_can_push;
  logic            w_found;
  logic [TAGW-1:0] w_idx;
  logic [TAGW:0]   w_sum;
  logic [TAGW-1:0] w_cand;
  logic [TAGW-1:0] w_rr_next;
  logic [NUM_REQS-1:0] w_grant;

  assign w_full     = (r_count == CNTW'(SIZE));
  assign w_empty    = (r_count == '0);
  assign w_pop      = !w_empty && bus.out_ready;
  assign w_can_push = !w_full || w_pop;
  // Grant is masked by reset so req_ready reads zero while reset is held,
  // even though the arbiter itself is purely combinational.
  assign w_push     = w_found && w_can_push && reset;

  // Scan requesters starting at r_rr_ptr, wrapping modulo NUM_REQS.
  // The extra sum bit keeps the wrap correct for non-power-of-two NUM_REQS.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (TAGW+1)'(k);
      if (w_sum >= (TAGW+1)'(NUM_REQS)) begin
        w_sum = w_sum - (TAGW+1)'(NUM_REQS);
      end
      w_cand = w_sum[TAGW-1:0];
      if (!w_found && bus.req_valid[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  assign w_rr_next = (w_idx == TAGW'(NUM_REQS-1)) ? '0 : w_idx + 1'b1;
  assign w_grant   = w_push ? (NUM_REQS'(1) << w_idx) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr_ptr <= w_rr_next;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is data-only and deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.req_data[w_idx*DATAW +: DATAW], w_idx};
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = r_mem[r_rd_ptr][ENTW-1:TAGW];
  assign bus.out_tag   = r_mem[r_rd_ptr][TAGW-1:0];
  assign bus.count     = r_count;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
endmodule
`default_nettype wire

// File: tb/tb_queue_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_queue_push_arbiter
// Description : Directed self-checking bench for queue_push_arbiter with
//               NUM_REQS=4, DATAW=8, SIZE=4. Inputs change 1 time unit after
//               the rising edge; outputs are sampled before the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_queue_push_arbiter;
  localparam int NUM_REQS = 4;
  localparam int DATAW    = 8;
  localparam int SIZE     = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  queue_push_arbiter_if #(.NUM_REQS(NUM_REQS), .DATAW(DATAW), .SIZE(SIZE)) bus ();

  queue_push_arbiter #(.NUM_REQS(NUM_REQS), .DATAW(DATAW), .SIZE(SIZE)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_g;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;

    // 1. Reset values, with all requesters asserting.
    repeat (3) tick();
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    bus.req_valid = 4'b0000;
    reset = 1'b1;

    // 2. Single push, one-cycle latency.
    tick();
    bus.req_valid = 4'b0100;
    bus.req_data  = {8'h00, 8'h5A, 8'h00, 8'h00};
    #1;
    chk("single_grant", 32'(bus.req_ready), 32'h4);
    chk("single_no_bypass", 32'(bus.out_valid), 0);
    tick();
    bus.req_valid = 4'b0000;
    chk("single_valid", 32'(bus.out_valid), 1);
    chk("single_data", 32'(bus.out_data), 32'h5A);
    chk("single_tag", 32'(bus.out_tag), 2);
    chk("single_count", 32'(bus.count), 1);
    do_reset();

    // 3. Round-robin fill, full backpressure, in-order drain.
    bus.req_valid = 4'b1111;
    bus.req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 4; k++) begin
      exp_g = 4'b0001 << k;
      #1;
      chk("fill_grant", 32'(bus.req_ready), 32'(exp_g));
      tick();
    end
    #1;
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_count", 32'(bus.count), 4);
    chk("fill_blocked", 32'(bus.req_ready), 0);
    bus.req_valid = 4'b0000;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("drain_valid", 32'(bus.out_valid), 1);
      chk("drain_data", 32'(bus.out_data), 32'h10 + k);
      chk("drain_tag", 32'(bus.out_tag), k);
      tick();
    end
    chk("drain_empty", 32'(bus.empty), 1);

    // 4. Fairness while draining: grants alternate 1,3,1,3.
    bus.req_valid = 4'b1010;
    bus.req_data  = {8'hB3, 8'h00, 8'hB1, 8'h00};
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      #1;
      chk("fair_grant", 32'(bus.req_ready), 32'(exp_g));
      tick();
      chk("fair_count", 32'(bus.count), 1);
    end
    bus.req_valid = 4'b0000;
    tick();
    chk("fair_empty", 32'(bus.empty), 1);

    // 5. Full queue accepts a push alongside a pop; 77 lands after wrap.
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_data  = {8'h23, 8'h22, 8'h21, 8'h20};
    repeat (4) tick();
    chk("wrap_full", 32'(bus.full), 1);
    bus.req_valid = 4'b0001;
    bus.req_data  = {8'h00, 8'h00, 8'h00, 8'h77};
    bus.out_ready = 1'b1;
    #1;
    chk("wrap_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 4'b0000;
    chk("wrap_count", 32'(bus.count), 4);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("wrap_data", 32'(bus.out_data), (k == 3) ? 32'h77 : 32'h21 + k);
      chk("wrap_tag", 32'(bus.out_tag), (k == 3) ? 0 : k + 1);
      tick();
    end
    chk("wrap_empty", 32'(bus.empty), 1);

    // 6. Asynchronous reset mid-stream.
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_data  = {8'h33, 8'h32, 8'h31, 8'h30};
    repeat (3) tick();
    chk("mid_count", 32'(bus.count), 3);
    reset = 1'b0;
    #1;
    chk("async_empty", 32'(bus.empty), 1);
    chk("async_out_valid", 32'(bus.out_valid), 0);
    chk("async_count", 32'(bus.count), 0);
    chk("async_req_ready", 32'(bus.req_ready), 0);
    reset = 1'b1;
    bus.req_valid = 4'b1000;
    bus.req_data  = {8'h99, 8'h00, 8'h00, 8'h00};
    #1;
    chk("post_grant", 32'(bus.req_ready), 32'h8);
    tick();
    chk("post_data", 32'(bus.out_data), 32'h99);
    chk("post_tag", 32'(bus.out_tag), 3);
    chk("post_count", 32'(bus.count), 1);
    bus.req_valid = 4'b0011;
    #1;
    chk("post_rr", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 4'b0000;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
